// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single fixed-latency memory.
// Port 0 is instruction fetch, port 1 is data. One access is in flight at a time:
// IDLE -> BUSY (MEM_LAT cycles) -> DONE -> IDLE.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mux_ctl
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       last;    // port served most recently; loser of a tie next time
    logic       we_lat;  // write flag of the access in flight
    logic       win;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    // Winner of the current arbitration: a lone requester wins, a tie goes to
    // the port that was not served last.
    always_comb begin
        win = req1;
        if (req0 && req1)
            win = ~last;
    end

    // Address and write data follow the registered select, so they are stable
    // for the whole ownership window.
    assign mem_addr  = mux_ctl ? addr1  : addr0;
    assign mem_wdata = mux_ctl ? wdata1 : wdata0;

    // Control FSM with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            mux_ctl <= 1'b0;
            last    <= 1'b1;
            we_lat  <= 1'b0;
            rdata   <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            // Strobes and completion pulses are single-cycle by default.
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state   <= BUSY;
                        mux_ctl <= win;
                        cnt     <= LAT_M1;
                        we_lat  <= win ? we1 : we0;
                        mem_en  <= 1'b1;
                        mem_we  <= win ? we1 : we0;
                        gnt0    <= ~win;
                        gnt1    <= win;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        // Last BUSY cycle: memory data is valid now.
                        state <= DONE;
                        if (!we_lat)
                            rdata <= mem_rdata;
                        done0 <= ~mux_ctl;
                        done1 <= mux_ctl;
                        last  <= mux_ctl;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions at MEM_LAT=2,
// plus hand sequences for held ties, dropped requests, reset mid-access and
// the MEM_LAT=1 / MEM_LAT=5 latency builds.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main DUT (MEM_LAT = 2)
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, done0, done1, mem_en, mem_we, mux_ctl;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mux_ctl(mux_ctl)
    );

    // Memory model: data valid only in the MEM_LAT-th cycle after issue.
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'h0000_1234 : {a[15:0], 16'hC0DE};
    endfunction
    logic [3:0]  age = 0;
    logic [31:0] lat_addr = 0;
    always @(posedge clk) begin
        if (mem_en) begin
            age <= 4'd1;
            lat_addr <= mem_addr;
        end else if (age != 0 && age != 15) age <= age + 4'd1;
    end
    assign mem_rdata = (age == 4'd1) ? rd_val(lat_addr) : 32'hBAD0_BAD0;

    // MEM_LAT = 1 instance
    logic        a_req = 0;
    logic        a_gnt0, a_gnt1, a_done0, a_done1, a_en, a_we, a_mux;
    logic [31:0] a_rdata, a_addr, a_wdata, a_mrd;
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .req0(a_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(32'h10), .addr1(32'h0), .wdata0(32'h0), .wdata1(32'h0),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1), .rdata(a_rdata),
        .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_rdata(a_mrd), .mux_ctl(a_mux)
    );
    assign a_mrd = a_en ? 32'h1111_0001 : 32'hBAD0_BAD0;

    // MEM_LAT = 5 instance
    logic        b_req = 0;
    logic        b_gnt0, b_gnt1, b_done0, b_done1, b_en, b_we, b_mux;
    logic [31:0] b_rdata, b_addr, b_wdata, b_mrd;
    logic [3:0]  b_age = 0;
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(5)) dut_l5 (
        .clk(clk), .reset(reset),
        .req0(b_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(32'h20), .addr1(32'h0), .wdata0(32'h0), .wdata1(32'h0),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1), .rdata(b_rdata),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_rdata(b_mrd), .mux_ctl(b_mux)
    );
    always @(posedge clk) begin
        if (b_en) b_age <= 4'd1;
        else if (b_age != 0 && b_age != 15) b_age <= b_age + 4'd1;
    end
    assign b_mrd = (b_age == 4'd4) ? 32'h5555_0005 : 32'hBAD0_BAD0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One transaction per record; fields: r0 r1 w0 w1 a0 a1 d0 d1 | win ewe eaddr ewdata erdata
    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        logic        win, ewe;
        logic [31:0] eaddr, ewdata, erdata;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int  k, k1, k5, last_en;
        bit  seen, s1, s5;
        logic exp_w;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 32'h40, 32'h0, 32'h0000_1234};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h80, 32'h0, 32'hDEAD_BEEF,
                    1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 32'h0000_1234};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'hA, 32'hB,
                    1'b0, 1'b0, 32'h100, 32'hA, 32'h0100_C0DE};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h104, 32'h208, 32'hC, 32'hD,
                    1'b1, 1'b0, 32'h208, 32'hD, 32'h0208_C0DE};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h300, 32'h0, 32'hE,
                    1'b1, 1'b0, 32'h300, 32'hE, 32'h0300_C0DE};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h304, 32'h0, 32'hF,
                    1'b1, 1'b0, 32'h304, 32'hF, 32'h0304_C0DE};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h14, 32'h1111_2222, 32'h5,
                    1'b0, 1'b1, 32'h10, 32'h1111_2222, 32'h0304_C0DE};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h24, 32'h20, 32'h6, 32'h3333_4444,
                    1'b1, 1'b1, 32'h20, 32'h3333_4444, 32'h0304_C0DE};

        // Reset, with both ports already requesting.
        req0 = 1; req1 = 1;
        repeat (3) @(negedge clk);
        chk("rst gnt0", gnt0, 0);    chk("rst gnt1", gnt1, 0);
        chk("rst done0", done0, 0);  chk("rst done1", done1, 0);
        chk("rst mem_en", mem_en, 0); chk("rst mem_we", mem_we, 0);
        chk("rst mux_ctl", mux_ctl, 0); chk("rst rdata", rdata, 0);
        reset = 0;

        // Held tie: grants alternate 0,1,0,1 with one grant every 4 cycles.
        last_en = 0;
        for (int t = 0; t < 4; t++) begin
            exp_w = t[0];
            seen = 0;
            for (int w = 0; w < 20 && !seen; w++) begin
                @(negedge clk);
                if (mem_en) seen = 1;
            end
            chk($sformatf("tie%0d grant seen", t), 32'(seen), 1);
            chk($sformatf("tie%0d mux_ctl", t), 32'(mux_ctl), 32'(exp_w));
            if (t > 0) chk($sformatf("tie%0d grant gap", t), cyc - last_en, 4);
            last_en = cyc;
            seen = 0;
            for (int w = 0; w < 20 && !seen; w++) begin
                @(negedge clk);
                if (done0 || done1) seen = 1;
            end
            chk($sformatf("tie%0d done seen", t), 32'(seen), 1);
            chk($sformatf("tie%0d done0", t), 32'(done0), 32'(!exp_w));
            chk($sformatf("tie%0d done1", t), 32'(done1), 32'(exp_w));
            if (t == 3) begin req0 = 0; req1 = 0; end
        end

        // Table of single transactions.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);  // IDLE cycle: request sampled here
            chk($sformatf("v%0d idle gnt", i), {gnt0, gnt1, done0, done1}, 0);
            req0 = vecs[i].r0; req1 = vecs[i].r1; we0 = vecs[i].w0; we1 = vecs[i].w1;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1; wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
            @(negedge clk);  // issue cycle
            chk($sformatf("v%0d mem_en", i), 32'(mem_en), 1);
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].ewe));
            chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].eaddr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].ewdata);
            chk($sformatf("v%0d mux_ctl", i), 32'(mux_ctl), 32'(vecs[i].win));
            chk($sformatf("v%0d gnt", i), {gnt0, gnt1}, {!vecs[i].win, vecs[i].win});
            @(negedge clk);  // second BUSY cycle
            chk($sformatf("v%0d busy2 strobes", i), {mem_en, mem_we, done0, done1}, 0);
            chk($sformatf("v%0d busy2 gnt", i), {gnt0, gnt1}, {!vecs[i].win, vecs[i].win});
            @(negedge clk);  // DONE
            chk($sformatf("v%0d done", i), {done0, done1}, {!vecs[i].win, vecs[i].win});
            chk($sformatf("v%0d done gnt", i), {gnt0, gnt1}, {!vecs[i].win, vecs[i].win});
            chk($sformatf("v%0d rdata", i), rdata, vecs[i].erdata);
            req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        end

        // Request dropped right after grant still completes.
        @(negedge clk);
        req0 = 1; addr0 = 32'h40;
        @(negedge clk);
        req0 = 0;
        chk("drop mem_en", 32'(mem_en), 1);
        @(negedge clk);
        @(negedge clk);
        chk("drop done0", 32'(done0), 1);
        chk("drop rdata", rdata, 32'h0000_1234);

        // Latency builds: done at cycle MEM_LAT+1.
        @(negedge clk);
        a_req = 1; b_req = 1;
        k1 = 0; k5 = 0; s1 = 0; s5 = 0;
        for (k = 1; k <= 20 && !(s1 && s5); k++) begin
            @(negedge clk);
            if (a_done0 && !s1) begin
                s1 = 1; k1 = k; a_req = 0;
                chk("lat1 rdata", a_rdata, 32'h1111_0001);
            end
            if (b_done0 && !s5) begin
                s5 = 1; k5 = k; b_req = 0;
                chk("lat5 rdata", b_rdata, 32'h5555_0005);
            end
        end
        a_req = 0; b_req = 0;
        chk("lat1 done cycle", k1, 2);
        chk("lat5 done cycle", k5, 6);

        // Reset in the second BUSY cycle aborts the access.
        repeat (3) @(negedge clk);
        req0 = 1; addr0 = 32'h100;
        @(negedge clk);
        chk("abort issue", 32'(mem_en), 1);
        @(negedge clk);
        reset = 1; req0 = 0;
        @(negedge clk);
        chk("abort outs", {gnt0, gnt1, done0, done1, mem_en, mem_we, mux_ctl}, 0);
        chk("abort rdata", rdata, 0);
        reset = 0;
        @(negedge clk);
        chk("abort after", {gnt0, gnt1, done0, done1, mem_en, mem_we}, 0);
        @(negedge clk);
        chk("abort after2", {gnt0, gnt1, done0, done1, mem_en, mem_we}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
